// File: rtl/uart_pkg.sv
// Shared definitions for the Uart8 link: receiver state encoding, data framing
// constants and the baud-tick divider computation.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Clocks per oversample tick, floor division.
    function automatic int calc_div(input int clock_rate, input int baud_rate,
                                    input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart8_rx_if.sv
// Receive-side port bundle of the Uart8 link: serial line and enable in,
// busy level plus done/error strobes and the received byte out.
interface uart8_rx_if;
    // rxDone and rxErr are single-cycle strobes with no back-pressure: the
    // consumer must take rxOut in the cycle rxDone is high. rxOut stays valid
    // until the next good frame. Both strobes are never high together.
    logic       rxEn;
    logic       rxIn;
    logic       rxBusy;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxOut;
    logic [2:0] rxState;

    modport slave (
        input  rxEn, rxIn,
        output rxBusy, rxDone, rxErr, rxOut, rxState
    );

    modport master (
        output rxEn, rxIn,
        input  rxBusy, rxDone, rxErr, rxOut, rxState
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and flags the last count. A
// synchronous clear re-aligns the tick phase to an external event.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart8_rx.sv
// 8N1 UART receiver: synchronises the line, detects the start edge, samples
// each bit at its midpoint and strobes done or framing error per frame.
module uart8_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    uart8_rx_if.slave  rx
);
    localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_STOP  = ST_STOP;
    localparam logic [2:0] S_BREAK = ST_BREAK;

    logic                 sync1_q, sync2_q, prev_q;
    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 tick, div_clr, rx_s, fall;

    assign rx_s = sync2_q;
    assign fall = prev_q && !rx_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (div_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        samp_d  = tick ? samp_q + SW'(1) : samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        div_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx.rxEn && fall) begin
                    div_clr = 1'b1;
                    samp_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick && samp_q == SAMP_MID) begin
                    state_d = rx_s ? S_IDLE : S_DATA;
                    bit_d   = '0;
                    samp_d  = '0;
                end
            end
            S_DATA: begin
                if (tick && samp_q == SAMP_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && samp_q == SAMP_LAST) begin
                    if (rx_s) begin
                        out_d   = shift_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a stuck-low line cannot start a frame.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rx.rxEn && state_q != S_IDLE) begin
            state_d = S_IDLE;
            out_d   = out_q;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            prev_q  <= IDLE_LEVEL;
            state_q <= S_IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= rx.rxIn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx.rxBusy  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign rx.rxDone  = done_q;
    assign rx.rxErr   = err_q;
    assign rx.rxOut   = out_q;
    assign rx.rxState = state_q;
endmodule

// File: tb/tb_uart8_rx.sv
// Directed bench for uart8_rx at 9600 baud with a reduced clock (DIV = 8, 128 clk per bit).
module tb_uart8_rx;
    localparam int CLOCK_RATE = 1228800;
    localparam int BAUD_RATE  = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = 128;
    localparam int LAT        = 1219;   // 3 + 9.5 * 128
    localparam int TOL        = 8;      // one tick

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   failures;
    int   done_cnt;
    int   err_cnt;
    int   both_cnt;
    int   start_cyc;
    logic prev_done;
    logic prev_err;
    logic [7:0] exp_q[$];
    int   done_cyc[$];

    uart8_rx_if rx_if ();

    uart8_rx #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx_if)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // driver: one 8N1 frame, caller is at a negedge
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int abort_bit, input bit chk_lat);
        rx_if.rxIn = 1'b0;
        start_cyc  = cyc;
        for (int j = 1; j <= BIT; j++) begin
            @(negedge clk);
            if (chk_lat && j == 2) check("busy_lat_2clk", rx_if.rxBusy, 1'b0);
            if (chk_lat && j == 3) check("busy_lat_3clk", rx_if.rxBusy, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            rx_if.rxIn = data[i];
            if (i == abort_bit) begin
                repeat (BIT / 2) @(negedge clk);
                check("abort_busy_before", rx_if.rxBusy, 1'b1);
                rx_if.rxEn = 1'b0;
                @(negedge clk);
                check("abort_busy_after", rx_if.rxBusy, 1'b0);
                repeat (BIT - BIT / 2 - 1) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rx_if.rxIn = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    // scoreboard: every rxDone pops one expected byte
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_if.rxDone) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("done_byte", rx_if.rxOut, exp_q.pop_front());
                check("done_busy_low", rx_if.rxBusy, 1'b0);
                check("done_width", prev_done, 1'b0);
            end
            if (rx_if.rxErr) begin
                err_cnt++;
                check("err_width", prev_err, 1'b0);
            end
            if (rx_if.rxDone && rx_if.rxErr) both_cnt++;
        end
        prev_done = rx_if.rxDone;
        prev_err  = rx_if.rxErr;
    end

    initial begin
        int d0;
        int e0;
        bit saw_busy;
        checks = 0; failures = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
        cyc = 0; start_cyc = 0; prev_done = 1'b0; prev_err = 1'b0;
        rstn = 1'b0;
        rx_if.rxIn = 1'b1;
        rx_if.rxEn = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", rx_if.rxBusy, 1'b0);
        check("rst_done", rx_if.rxDone, 1'b0);
        check("rst_err", rx_if.rxErr, 1'b0);
        check("rst_out", rx_if.rxOut, 8'h00);
        check("rst_state", rx_if.rxState, 3'd0);
        rstn = 1'b1;
        rx_if.rxEn = 1'b1;
        repeat (BIT) @(negedge clk);

        // two frames 0x45, 0x7F
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h7F);
        send_frame(8'h45, 1'b1, -1, 1'b1);
        check_range("done_latency", done_cyc[done_cyc.size()-1] - start_cyc, LAT - TOL, LAT + TOL);
        send_frame(8'h7F, 1'b1, -1, 1'b0);
        repeat (BIT) @(negedge clk);
        check("two_frames_done", done_cnt, 2);
        check("two_frames_err", err_cnt, 0);
        check("two_frames_out", rx_if.rxOut, 8'h7F);

        // asynchronous reset during DATA
        fork
            send_frame(8'h45, 1'b1, -1, 1'b0);
            begin
                repeat (3 * BIT) @(negedge clk);
                check("midrst_busy_before", rx_if.rxBusy, 1'b1);
                rstn = 1'b0;
                #1;
                check("midrst_busy", rx_if.rxBusy, 1'b0);
                check("midrst_done", rx_if.rxDone, 1'b0);
                check("midrst_err", rx_if.rxErr, 1'b0);
                check("midrst_out", rx_if.rxOut, 8'h00);
                check("midrst_state", rx_if.rxState, 3'd0);
            end
        join
        rstn = 1'b1;
        repeat (BIT) @(negedge clk);
        exp_q.push_back(8'h45);
        send_frame(8'h45, 1'b1, -1, 1'b0);
        check("after_rst_done", done_cnt, 3);
        check("after_rst_out", rx_if.rxOut, 8'h45);

        // glitch shorter than half a bit
        d0 = done_cnt; e0 = err_cnt; saw_busy = 1'b0;
        rx_if.rxIn = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rx_if.rxBusy) saw_busy = 1'b1;
        end
        rx_if.rxIn = 1'b1;
        repeat (3 * BIT) begin
            @(negedge clk);
            if (rx_if.rxBusy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", saw_busy, 1'b1);
        check("glitch_busy_end", rx_if.rxBusy, 1'b0);
        check("glitch_state", rx_if.rxState, 3'd0);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // framing error, line held low for 3 bit times
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b0, -1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        check("ferr_err", err_cnt - e0, 1);
        check("ferr_done", done_cnt - d0, 0);
        check("ferr_out_kept", rx_if.rxOut, 8'h45);
        check("ferr_state_break", rx_if.rxState, 3'd4);
        check("ferr_busy", rx_if.rxBusy, 1'b0);
        rx_if.rxIn = 1'b1;
        repeat (8) @(negedge clk);
        check("ferr_state_idle", rx_if.rxState, 3'd0);
        repeat (BIT) @(negedge clk);

        // disable during bit 4, then receive normally
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b1, 4, 1'b0);
        check("abort_done", done_cnt - d0, 0);
        check("abort_err", err_cnt - e0, 0);
        check("abort_out_kept", rx_if.rxOut, 8'h45);
        rx_if.rxEn = 1'b1;
        repeat (BIT) @(negedge clk);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        check("reen_done", done_cnt - d0, 1);
        check("reen_out", rx_if.rxOut, 8'h3C);

        // back-to-back 0x00, 0xFF with no idle gap
        d0 = done_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, -1, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        repeat (BIT) @(negedge clk);
        check("b2b_done", done_cnt - d0, 2);
        if (done_cnt - d0 == 2)
            check_range("b2b_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2],
                        10 * BIT - TOL, 10 * BIT + TOL);
        check("b2b_out", rx_if.rxOut, 8'hFF);

        check("exp_q_drained", exp_q.size(), 0);
        check("never_both", both_cnt, 0);
        check("total_err", err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart8_rx.md
# uart8_rx

Standalone 8N1 UART receiver for the `Uart8` link. It deserialises the line driven by a `Uart8` transmitter (`txOut`) and presents each byte on a done/error strobe interface matching the `Uart8` rx port set. It sits between a board RX pin, or a peer `txOut`, and the consuming logic. Its purpose is to let receive-only designs and benches instantiate reception without the transmitter half.

## Interface

Parameters:
- `CLOCK_RATE`, default 12000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in baud.
- `OVERSAMPLE`, default 16: sample ticks per bit. Must be a power of two, at least 8.

Ports:
- `clk`, in, 1: system clock. Single clock domain; everything is sampled on the rising edge.
- `rstn`, in, 1: reset, asynchronous and active-low.
- `rxEn`, in, 1: receiver enable.
- `rxIn`, in, 1: serial line; idle high; asynchronous to `clk`.
- `rxBusy`, out, 1: frame in progress.
- `rxDone`, out, 1: one-cycle strobe; valid byte on `rxOut`.
- `rxErr`, out, 1: one-cycle strobe; framing error (stop bit low).
- `rxOut`, out, 8: last correctly received byte.

## Operation

- `rxIn` passes through a 2-flop synchroniser, reset to 1. All logic below uses the synchronised value `rxS`.
- Tick divider: `DIV = CLOCK_RATE / (BAUD_RATE*OVERSAMPLE)`, integer floor. With the defaults, `DIV` = 78, so one bit is 1248 clk.
  - The divider counts 0..DIV-1 and emits `tick` on DIV-1.
  - It is forced to 0 on start detection, for phase alignment.
- Sample counter: `log2(OVERSAMPLE)` bits, increments on `tick`, wraps naturally.
- FSM states:
  - IDLE: waits for `rxEn`=1 and a 1→0 transition on `rxS`. On that transition, clear the divider and sample counter, then go to START.
  - START: when the sample counter reaches OVERSAMPLE/2-1 on a tick (bit midpoint):
    - `rxS`=0: go to DATA, clear the bit index, restart the sample counter at 0.
    - `rxS`=1: false start; go to IDLE with no strobe.
  - DATA: on each full-bit midpoint (sample counter wraps through OVERSAMPLE-1), shift `rxS` into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: at the midpoint:
    - `rxS`=1: load `rxOut` from the shift register, pulse `rxDone`, go to IDLE.
    - `rxS`=0: pulse `rxErr`, leave `rxOut` unchanged, go to BREAK.
  - BREAK: wait until `rxS`=1, then go to IDLE. This prevents a low line from retriggering a frame.
- `rxBusy` = 1 in START, DATA and STOP; 0 in IDLE and BREAK.
- `rxEn` low in any state other than IDLE: abort to IDLE on the next clk. No strobe; `rxOut` retained.
- A falling edge in IDLE while `rxEn`=0 is ignored. Enabling with the line already low does not start a frame; a fresh 1→0 transition is required.

## Timing

- Reset values: `rxBusy`=0, `rxDone`=0, `rxErr`=0, `rxOut`=8'h00, FSM=IDLE, synchroniser=1. Reset takes effect immediately and asynchronously, including mid-frame.
- Start detect latency: `rxBusy` rises 3 clk after the `rxIn` falling edge (2 synchroniser stages plus the FSM register).
- `rxDone`/`rxErr` assert at the stop-bit midpoint, about 9.5 bit times after the start edge: 9.5×1248 + 3 = 11859 clk ±DIV with the defaults.
- `rxOut` changes in the same cycle `rxDone` is high and holds until the next good frame.
- `rxDone` and `rxErr` are never both high in the same cycle. Each is high for exactly 1 clk per frame.
- `rxBusy` falls in the same cycle the strobe is high.
- Back-to-back frames: a start edge immediately after the stop-bit midpoint (within the second half of the stop bit) is accepted.
- Tolerance: sampling at the midpoint tolerates ±4% total baud mismatch.

## Structure

- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - the `DIV` computation as a function of the parameters;
  - the constants DATA_BITS = 8 and the idle level 1'b1.
- Sub-module `uart_baud_tick` contains the divider with a synchronous clear input. The same module is intended for later reuse in the tx path.

## Test plan

- Reset mid-frame: drive `rstn` low during DATA → all outputs 0 in the same cycle; the next clean frame with 8'h45 gives `rxDone`=1, `rxOut`=8'h45.
- Two frames at 9600 baud from a `Uart8` transmitter: 8'b01000101 then 8'b01111111 → exactly two `rxDone` pulses, `rxOut`=8'h45 then 8'h7F, `rxErr` never high.
- Glitch: `rxIn` low for 300 clk (under half a bit) in IDLE → `rxBusy` pulses, no `rxDone`/`rxErr`, FSM back in IDLE.
- Framing error: send 8'hA5 with the stop bit driven low, line held low 3 bit times → one `rxErr` pulse, `rxOut` keeps its previous value, no new frame until the line returns high.
- Disable mid-frame: drop `rxEn` during bit 4 of 8'h3C → `rxBusy` falls next clk, no strobe; re-enable, send 8'h3C → `rxOut`=8'h3C.
- Back-to-back: 8'h00 and 8'hFF with zero idle between frames → two `rxDone` pulses 10 bit times ±1 tick apart, correct bytes.
